// File: rtl/r_type_pipe_pkg.sv
// Shared definitions for the two-stage R-type execution unit: ALU op encodings,
// the normal-mode constant and the legality check used by both stages.
package r_type_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  localparam logic [1:0] MODE_NORMAL = 2'b00;

  // An instruction is legal only in normal mode with one of the six known ops.
  function automatic logic legal_funct(input logic [5:0] f);
    logic op_ok;
    case (f[3:0])
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: op_ok = 1'b1;
      default:                                       op_ok = 1'b0;
    endcase
    return op_ok && (f[5:4] == MODE_NORMAL);
  endfunction

endpackage

// File: rtl/r_type_pipe_alu_core.sv
// Combinational R-type ALU: result plus zero/carry/overflow flags, and an error
// flag with a forced-zero result for any illegal funct.
module alu_core
  import r_type_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [5:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             err
);

  logic [WIDTH:0] sum;

  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    err    = 1'b0;
    sum    = '0;
    if (!legal_funct(op)) begin
      err = 1'b1;
    end else begin
      case (op[3:0])
        OP_AND: result = a & b;
        OP_OR:  result = a | b;
        OP_NOR: result = ~(a | b);
        OP_ADD: begin
          sum    = {1'b0, a} + {1'b0, b};
          result = sum[WIDTH-1:0];
          carry  = sum[WIDTH];
          ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
        end
        // a + ~b + 1: the carry out is the inverse borrow, i.e. a >= b unsigned.
        OP_SUB: begin
          sum    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
          result = sum[WIDTH-1:0];
          carry  = sum[WIDTH];
          ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
        end
        OP_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
        default: err = 1'b1;
      endcase
    end
  end

  assign zero = (result == '0);

endmodule

// File: rtl/r_type_pipe.sv
// Two-stage R-type execution unit: register file, operand latch (S1), result
// register (S2) with writeback, full forwarding from both stages, valid/ready flow.
module r_type_pipe
  import r_type_pkg::*;
#(
  parameter int  WIDTH = 32,
  parameter int  NREGS = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    r1,
  input  logic [AW-1:0]    r2,
  input  logic [AW-1:0]    r3,
  input  logic [5:0]       funct,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW-1:0]    out_rd,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_err,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  logic [WIDTH-1:0] regs_q [NREGS];

  logic             s1_valid_q;
  logic [AW-1:0]    s1_rd_q;
  logic [5:0]       s1_funct_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;

  logic             s2_valid_q;
  logic [AW-1:0]    s2_rd_q;
  logic [WIDTH-1:0] s2_result_q;
  logic             s2_zero_q, s2_carry_q, s2_ovf_q, s2_err_q;

  logic [WIDTH-1:0] alu_result;
  logic             alu_zero, alu_carry, alu_ovf, alu_err;
  logic [WIDTH-1:0] op_a_d, op_b_d;
  logic             s1_advance, s1_fwd, s2_fwd, wb_en;

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .a      (s1_a_q),
    .b      (s1_b_q),
    .op     (s1_funct_q),
    .result (alu_result),
    .zero   (alu_zero),
    .carry  (alu_carry),
    .ovf    (alu_ovf),
    .err    (alu_err)
  );

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; valid never depends on ready, and out_* hold while out_valid & !out_ready.
  assign s1_advance = !s2_valid_q || out_ready;
  assign in_ready   = !s1_valid_q || s1_advance;
  assign wb_en      = s2_valid_q && out_ready && !s2_err_q && (s2_rd_q != '0);

  // Youngest producer wins: S1's live ALU output, then S2, then the register file.
  assign s1_fwd = s1_valid_q && !alu_err;
  assign s2_fwd = s2_valid_q && !s2_err_q;

  assign op_a_d = (r1 == '0)                 ? '0          :
                  (s1_fwd && s1_rd_q == r1)  ? alu_result  :
                  (s2_fwd && s2_rd_q == r1)  ? s2_result_q : regs_q[r1];
  assign op_b_d = (r2 == '0)                 ? '0          :
                  (s1_fwd && s1_rd_q == r2)  ? alu_result  :
                  (s2_fwd && s2_rd_q == r2)  ? s2_result_q : regs_q[r2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wb_en) begin
      regs_q[s2_rd_q] <= s2_result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_rd_q    <= '0;
      s1_funct_q <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_rd_q    <= r3;
        s1_funct_q <= funct;
        s1_a_q     <= op_a_d;
        s1_b_q     <= op_b_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q  <= 1'b0;
      s2_rd_q     <= '0;
      s2_result_q <= '0;
      s2_zero_q   <= 1'b0;
      s2_carry_q  <= 1'b0;
      s2_ovf_q    <= 1'b0;
      s2_err_q    <= 1'b0;
    end else if (s1_advance) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_rd_q     <= s1_rd_q;
        s2_result_q <= alu_result;
        s2_zero_q   <= alu_zero;
        s2_carry_q  <= alu_carry;
        s2_ovf_q    <= alu_ovf;
        s2_err_q    <= alu_err;
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_rd     = s2_rd_q;
  assign out_result = s2_result_q;
  assign out_zero   = s2_zero_q;
  assign out_carry  = s2_carry_q;
  assign out_ovf    = s2_ovf_q;
  assign out_err    = s2_err_q;
  assign dbg_data   = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

endmodule

// File: tb/tb_r_type_pipe.sv
// Self-checking bench for r_type_pipe: architectural reference model feeding an
// expected-result queue, plus directed scenario tasks with inline checks.
module tb_r_type_pipe;

  localparam int WIDTH = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int EW    = 4 + AW + WIDTH;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  localparam logic [5:0] F_AND = 6'b000000, F_OR  = 6'b000001, F_ADD = 6'b000010;
  localparam logic [5:0] F_SUB = 6'b000110, F_SLT = 6'b000111, F_NOR = 6'b001100;
  localparam logic [5:0] F_BADM = 6'b010010, F_BADO = 6'b000011;

  logic             clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [AW-1:0]    r1, r2, r3, out_rd, dbg_addr;
  logic [5:0]       funct;
  logic [WIDTH-1:0] out_result, dbg_data;
  logic             out_zero, out_carry, out_ovf, out_err;

  logic [WIDTH-1:0] model_regs [NREGS];
  logic [EW-1:0]    exp_q [$];
  int               checks, errors, stalls;
  logic             rand_bp;

  r_type_pipe #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .r1(r1), .r2(r2), .r3(r3), .funct(funct),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_result(out_result), .out_zero(out_zero), .out_carry(out_carry),
    .out_ovf(out_ovf), .out_err(out_err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] model_exec(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [5:0] f, input logic [AW-1:0] rd);
    logic [WIDTH-1:0] res;
    logic [WIDTH:0]   wide;
    logic             c, o, e;
    longint           sa, sb, sr;
    res = '0; c = 1'b0; o = 1'b0; e = 1'b0; wide = '0; sr = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (f[5:4] != 2'b00) e = 1'b1;
    else begin
      case (f[3:0])
        4'b0000: res = a & b;
        4'b0001: res = a | b;
        4'b1100: res = ~(a | b);
        4'b0010: begin
          wide = {1'b0, a} + {1'b0, b};
          res  = wide[WIDTH-1:0];
          c    = wide[WIDTH];
          sr   = sa + sb;
          o    = (sr > SMAX) || (sr < SMIN);
        end
        4'b0110: begin
          res = a - b;
          c   = (a >= b);
          sr  = sa - sb;
          o   = (sr > SMAX) || (sr < SMIN);
        end
        4'b0111: res = (sa < sb) ? 32'd1 : 32'd0;
        default: e = 1'b1;
      endcase
    end
    return {e, o, c, (res == '0), rd, res};
  endfunction

  task automatic push_model(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                            input logic [AW-1:0] d, input logic [5:0] f);
    logic [EW-1:0] e;
    e = model_exec(model_regs[a1], model_regs[a2], f, d);
    exp_q.push_back(e);
    if (!e[EW-1] && d != '0) model_regs[d] = e[WIDTH-1:0];
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic [AW-1:0] d, input logic [5:0] f);
    r1 = a1; r2 = a2; r3 = d; funct = f; in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        push_model(a1, a2, d, f);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      stalls++;
    end
    checks++; errors++;
    $display("FAIL issue_timeout: in_ready=%0b after 50 cycles, required 1", in_ready);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic wait_out();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) return;
    end
    checks++; errors++;
    $display("FAIL out_timeout: out_valid=0 after 20 cycles, required 1");
  endtask

  task automatic apply_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    exp_q.delete();
    for (int i = 0; i < NREGS; i++) model_regs[i] = '0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] got, want;
    if (!rst && out_valid && out_ready) begin
      got = {out_err, out_ovf, out_carry, out_zero, out_rd, out_result};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got rd=%0d result=%h, required no output", out_rd, out_result);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL sb_result: got {err,ovf,c,z,rd,res}=%h, required %h", got, want);
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    checks++;
    if ({in_ready, out_valid, out_rd, out_result, out_zero, out_carry, out_ovf, out_err} !==
        {1'b1, {(EW+1){1'b0}}}) begin
      errors++;
      $display("FAIL reset_outputs: in_ready=%0b out_valid=%0b result=%h, required 1 0 0",
               in_ready, out_valid, out_result);
    end
    rst = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      dbg_addr = AW'(i); #1;
      checks++;
      if (dbg_data !== '0) begin
        errors++;
        $display("FAIL reset_reg%0d: got %h, required 0", i, dbg_data);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    issue(0, 0, 10, F_NOR);   // R10 = -1
    issue(0, 10, 11, F_SUB);  // R11 = 1
    issue(11, 11, 12, F_ADD); // R12 = 2
    issue(12, 11, 13, F_ADD); // R13 = 3
    issue(13, 12, 14, F_ADD); // R14 = 5
    issue(14, 12, 15, F_ADD); // R15 = 7
    issue(14, 0, 1, F_OR);    // R1 = 5
    issue(15, 0, 2, F_OR);    // R2 = 7
    wait_drain();
    issue(1, 2, 3, F_ADD);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL add_latency_early: out_valid=%0b, required 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, out_rd, out_result, out_zero} !== {1'b1, 5'd3, 32'd12, 1'b0}) begin
      errors++;
      $display("FAIL add_result: valid=%0b rd=%0d result=%h zero=%0b, required 1 3 0000000c 0",
               out_valid, out_rd, out_result, out_zero);
    end
    wait_drain();
    dbg_addr = 3; #1;
    checks++;
    if (dbg_data !== 32'd12) begin
      errors++; $display("FAIL add_wb_r3: got %h, required 0000000c", dbg_data);
    end
  endtask

  task automatic test_sub_flags();
    issue(13, 14, 8, F_SUB);
    wait_out();
    checks++;
    if ({out_result, out_carry, out_ovf, out_err} !== {32'hFFFFFFFE, 3'b000}) begin
      errors++;
      $display("FAIL sub_3_5: result=%h carry=%0b ovf=%0b, required fffffffe 0 0",
               out_result, out_carry, out_ovf);
    end
    wait_drain();
    issue(11, 0, 20, F_OR);
    for (int i = 0; i < 31; i++) issue(20, 20, 20, F_ADD);
    issue(20, 0, 21, F_NOR);  // R21 = 0x7FFFFFFF
    wait_drain();
    issue(21, 11, 22, F_ADD);
    wait_out();
    checks++;
    if ({out_result, out_carry, out_ovf} !== {32'h80000000, 2'b01}) begin
      errors++;
      $display("FAIL add_ovf: result=%h carry=%0b ovf=%0b, required 80000000 0 1",
               out_result, out_carry, out_ovf);
    end
    wait_drain();
    issue(10, 11, 23, F_ADD);
    wait_out();
    checks++;
    if ({out_result, out_zero, out_carry, out_ovf} !== {32'h0, 3'b110}) begin
      errors++;
      $display("FAIL add_carry: result=%h zero=%0b carry=%0b ovf=%0b, required 0 1 1 0",
               out_result, out_zero, out_carry, out_ovf);
    end
    wait_drain();
    issue(10, 11, 24, F_SLT);
    wait_out();
    checks++;
    if (out_result !== 32'd1) begin
      errors++; $display("FAIL slt_neg: result=%h, required 00000001", out_result);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    issue(12, 0, 1, F_OR);    // R1 = 2
    wait_drain();
    stalls = 0;
    issue(1, 1, 4, F_ADD);
    issue(4, 4, 5, F_ADD);
    wait_drain();
    checks++;
    if (stalls != 0) begin
      errors++; $display("FAIL b2b_stall: stalled %0d cycles, required 0", stalls);
    end
    dbg_addr = 5; #1;
    checks++;
    if (dbg_data !== 32'd8) begin
      errors++; $display("FAIL b2b_r5: got %h, required 00000008", dbg_data);
    end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0]    ta [3] = '{11, 6, 7};
    logic [AW-1:0]    tb [3] = '{12, 13, 11};
    logic [AW-1:0]    td [3] = '{6, 7, 8};
    logic [5:0]       tf [3] = '{F_ADD, F_ADD, F_SUB};
    int               acc;
    logic             seen;
    logic [EW-1:0]    held, now;
    acc = 0; seen = 1'b0; held = '0;
    out_ready = 1'b0;
    r1 = ta[0]; r2 = tb[0]; r3 = td[0]; funct = tf[0]; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid) begin
        now = {out_err, out_ovf, out_carry, out_zero, out_rd, out_result};
        if (!seen) begin
          held = now; seen = 1'b1;
        end else begin
          checks++;
          if (now !== held) begin
            errors++; $display("FAIL bp_stable: got %h, required %h", now, held);
          end
        end
      end
      if (in_ready && acc < 3) begin
        push_model(ta[acc], tb[acc], td[acc], tf[acc]);
        acc++;
      end
      @(posedge clk); #1;
      if (acc < 3) begin
        r1 = ta[acc]; r2 = tb[acc]; r3 = td[acc]; funct = tf[acc];
      end else in_valid = 1'b0;
    end
    checks++;
    if (acc != 2 || in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_accepted: accepted %0d in_ready=%0b, required 2 0", acc, in_ready);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && acc < 3; c++) begin
      @(negedge clk);
      if (in_ready) begin
        push_model(ta[acc], tb[acc], td[acc], tf[acc]);
        acc++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (acc != 3) begin
      errors++; $display("FAIL bp_third: accepted %0d, required 3", acc);
    end
    wait_drain();
    dbg_addr = 8; #1;
    checks++;
    if (dbg_data !== 32'd5) begin
      errors++; $display("FAIL bp_r8: got %h, required 00000005", dbg_data);
    end
  endtask

  task automatic test_r0_illegal();
    issue(11, 11, 0, F_ADD);
    wait_out();
    checks++;
    if (out_rd !== 5'd0 || out_result !== 32'd2) begin
      errors++; $display("FAIL r0_out: rd=%0d result=%h, required 0 00000002", out_rd, out_result);
    end
    wait_drain();
    issue(0, 11, 9, F_ADD);   // R0 used as an operand must still be 0
    wait_drain();
    dbg_addr = 9; #1;
    checks++;
    if (dbg_data !== 32'd1) begin
      errors++; $display("FAIL r0_read: R9=%h, required 00000001", dbg_data);
    end
    issue(11, 11, 14, F_BADM);
    wait_out();
    checks++;
    if ({out_err, out_result} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL illegal_mode: err=%0b result=%h, required 1 0", out_err, out_result);
    end
    wait_drain();
    issue(11, 12, 14, F_BADO);
    issue(14, 0, 16, F_OR);   // must see the untouched R14
    wait_drain();
    dbg_addr = 14; #1;
    checks++;
    if (dbg_data !== 32'd5) begin
      errors++; $display("FAIL illegal_nowb: R14=%h, required 00000005", dbg_data);
    end
  endtask

  task automatic test_random();
    logic [5:0] fl [8] = '{F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT, F_BADO, F_BADM};
    rand_bp = 1'b1;
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      issue(AW'($urandom_range(0, 16)), AW'($urandom_range(0, 16)),
            AW'($urandom_range(0, 31)), fl[$urandom_range(0, 7)]);
    end
    rand_bp = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    wait_drain();
    for (int i = 1; i < NREGS; i++) begin
      dbg_addr = AW'(i); #1;
      checks++;
      if (dbg_data !== model_regs[i]) begin
        errors++; $display("FAIL rand_reg%0d: got %h, required %h", i, dbg_data, model_regs[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    issue(11, 11, 24, F_ADD);
    issue(12, 12, 25, F_ADD);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL midrst_setup: out_valid=%0b in_ready=%0b, required 1 0", out_valid, in_ready);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_out: out_valid=%0b in_ready=%0b, required 0 1", out_valid, in_ready);
    end
    exp_q.delete();
    for (int i = 0; i < NREGS; i++) model_regs[i] = '0;
    for (int i = 0; i < NREGS; i++) begin
      dbg_addr = AW'(i); #1;
      checks++;
      if (dbg_data !== '0) begin
        errors++; $display("FAIL midrst_reg%0d: got %h, required 0", i, dbg_data);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    issue(11, 11, 26, F_ADD);
    wait_drain();
  endtask

  initial begin
    checks = 0; errors = 0; stalls = 0; rand_bp = 1'b0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    r1 = '0; r2 = '0; r3 = '0; funct = '0; dbg_addr = '0;
    test_reset();
    test_add();
    test_sub_flags();
    test_back_to_back();
    test_backpressure();
    test_r0_illegal();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
